// File: rtl/relu_maxpool_pkg.sv
// Shared constants, state encoding and helpers for the CNN post-processing
// stages. The derived constants describe the default frame geometry; blocks
// with other geometries derive their own copies from their parameters.
package cnn_pkg;

    localparam int DW     = 32;
    localparam int DEF_M  = 3;
    localparam int DEF_RP = 25;
    localparam int DEF_CP = 25;

    localparam int PR        = DEF_RP / 2;
    localparam int PC        = DEF_CP / 2;
    localparam int OUT_WORDS = DEF_M * PR * PC;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Two's-complement maximum of two DW-wide words.
    function automatic logic [DW-1:0] smax(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

endpackage

// File: rtl/relu_maxpool_if.sv
// Stream/control bundle for relu_maxpool.
//   master: drives start, in_data, in_valid; observes the pooled stream.
//   slave : the pooling stage itself.
interface relu_maxpool_if #(
    parameter int DW = cnn_pkg::DW
);
    logic          start;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [31:0]   out_addr;
    logic          busy;
    logic          done;

    modport master (
        output start, in_data, in_valid,
        input  out_data, out_valid, out_addr, busy, done
    );

    modport slave (
        input  start, in_data, in_valid,
        output out_data, out_valid, out_addr, busy, done
    );
endinterface

// File: rtl/relu_maxpool_line_buf.sv
// pool_line_buf: one row of horizontal maxima awaiting their vertical partner.
//   clk          : write clock
//   we/waddr/wdata: write port
//   raddr/rdata  : asynchronous read port
// Contents are not reset; every entry is written before it is read.
module pool_line_buf #(
    parameter int DEPTH = cnn_pkg::PC,
    parameter int DW    = cnn_pkg::DW,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/relu_maxpool.sv
// relu_maxpool: streaming ReLU followed by 2x2 stride-2 max-pool.
//   clk : clock, rising edge
//   rst : synchronous reset, active low
//   bus : slave side of relu_maxpool_if (start, in_data/in_valid in;
//         out_data/out_valid/out_addr, busy, done out)
// Input is raster order (channel, row, column). Trailing odd row/column of
// each map is consumed and dropped.
module relu_maxpool #(
    parameter int M  = cnn_pkg::DEF_M,
    parameter int RP = cnn_pkg::DEF_RP,
    parameter int CP = cnn_pkg::DEF_CP,
    parameter int DW = cnn_pkg::DW
) (
    input  logic         clk,
    input  logic         rst,
    relu_maxpool_if.slave bus
);
    import cnn_pkg::*;

    localparam int HR = RP / 2;
    localparam int HC = CP / 2;
    localparam int CW = $clog2(CP + 1);
    localparam int RW = $clog2(RP + 1);
    localparam int MW = $clog2(M + 1);
    localparam int AW = (HC > 1) ? $clog2(HC) : 1;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [MW-1:0] ch;
    logic [DW-1:0] h_reg, v, h, lb_rd;
    logic [AW-1:0] idx;
    logic          acc, col_last, row_last, ch_last, pair_col, pair_row, lb_we;

    // start outranks a same-cycle sample.
    assign acc      = (state == RUN) && bus.in_valid && !bus.start;
    assign v        = bus.in_data[DW-1] ? '0 : bus.in_data;
    assign h        = smax(h_reg, v);
    assign col_last = (col == CW'(CP - 1));
    assign row_last = (row == RW'(RP - 1));
    assign ch_last  = (ch == MW'(M - 1));
    // Only columns/rows inside complete 2x2 windows take part.
    assign pair_col = col[0] && (col < CW'(2 * HC));
    assign pair_row = row < RW'(2 * HR);
    assign idx      = col[AW:1];
    assign lb_we    = acc && pair_col && pair_row && !row[0];

    pool_line_buf #(.DEPTH(HC), .DW(DW), .AW(AW)) u_lbuf (
        .clk  (clk),
        .we   (lb_we),
        .waddr(idx),
        .wdata(h),
        .raddr(idx),
        .rdata(lb_rd)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            col           <= '0;
            row           <= '0;
            ch            <= '0;
            h_reg         <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_addr  <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.done      <= 1'b0;
            // Address names the word currently on out_data, so step after it.
            if (bus.out_valid) bus.out_addr <= bus.out_addr + 32'd1;

            if (bus.start) begin
                state        <= RUN;
                bus.busy     <= 1'b1;
                col          <= '0;
                row          <= '0;
                ch           <= '0;
                bus.out_addr <= '0;
            end else if (acc) begin
                if (!col[0]) h_reg <= v;
                if (pair_col && pair_row && row[0]) begin
                    bus.out_data  <= smax(lb_rd, h);
                    bus.out_valid <= 1'b1;
                end
                if (col_last) begin
                    col <= '0;
                    if (row_last) begin
                        row <= '0;
                        ch  <= ch_last ? '0 : ch + MW'(1);
                    end else begin
                        row <= row + RW'(1);
                    end
                end else begin
                    col <= col + CW'(1);
                end
                if (col_last && row_last && ch_last) begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_relu_maxpool.sv
module tb_relu_maxpool;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          sel = 0;
    logic        start_s = 1'b0, valid_s = 1'b0;
    logic [31:0] data_s = '0;

    always #5 clk = ~clk;

    relu_maxpool_if #(.DW(32)) ifa ();
    relu_maxpool_if #(.DW(32)) ifb ();
    relu_maxpool_if #(.DW(32)) ifc ();

    assign ifa.start = start_s && (sel == 0);
    assign ifb.start = start_s && (sel == 1);
    assign ifc.start = start_s && (sel == 2);
    assign ifa.in_valid = valid_s && (sel == 0);
    assign ifb.in_valid = valid_s && (sel == 1);
    assign ifc.in_valid = valid_s && (sel == 2);
    assign ifa.in_data = data_s;
    assign ifb.in_data = data_s;
    assign ifc.in_data = data_s;

    relu_maxpool #(.M(1), .RP(4), .CP(4), .DW(32)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    relu_maxpool #(.M(1), .RP(5), .CP(5), .DW(32)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    relu_maxpool #(.M(3), .RP(25), .CP(25), .DW(32)) dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    logic        o_valid, o_done, o_busy;
    logic [31:0] o_data, o_addr;
    always_comb begin
        o_valid = ifa.out_valid; o_done = ifa.done; o_busy = ifa.busy;
        o_data  = ifa.out_data;  o_addr = ifa.out_addr;
        if (sel == 1) begin
            o_valid = ifb.out_valid; o_done = ifb.done; o_busy = ifb.busy;
            o_data  = ifb.out_data;  o_addr = ifb.out_addr;
        end else if (sel == 2) begin
            o_valid = ifc.out_valid; o_done = ifc.done; o_busy = ifc.busy;
            o_data  = ifc.out_data;  o_addr = ifc.out_addr;
        end
    end

    // ---------------- reference model ----------------
    typedef struct { int due; int val; int addr; } exp_t;
    exp_t q[$];
    int   frame[0:1874];
    int   m_m = 1, m_rp = 4, m_cp = 4;
    bit   armed = 1'b0;
    int   n = 0;
    int   done_at = -1, rise_at = -1, fall_at = -1;
    bit   busy_model = 1'b0;
    bit   run_chk = 1'b0;
    int   tick = 0;
    int   checks = 0, errors = 0;
    int   got[$];
    int   n_valid = 0, n_done = 0, last_addr = -1;

    always @(posedge clk) tick <= tick + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at tick %0d: got %0d expected %0d", nm, tick, act, exp);
        end
    endtask

    function automatic int relu(input int x);
        return (x < 0) ? 0 : x;
    endfunction

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Presents one cycle of stimulus (called at posedge+1) and updates the model.
    task automatic drive(input bit st, input bit vl, input int d, input bit r);
        int   c, rw, cl;
        exp_t e;
        rst = r; start_s = st; valid_s = vl; data_s = d;
        if (!r) begin
            q.delete(); armed = 0; done_at = -1; rise_at = -1; fall_at = tick + 1;
        end else if (st) begin
            armed = 1; n = 0; rise_at = tick + 1; fall_at = -1;
        end else if (vl && armed) begin
            frame[n] = d;
            c  = n / (m_rp * m_cp);
            rw = (n / m_cp) % m_rp;
            cl = n % m_cp;
            if (rw % 2 == 1 && cl % 2 == 1 && rw < 2 * (m_rp / 2) && cl < 2 * (m_cp / 2)) begin
                e.val  = mx(mx(relu(frame[n - m_cp - 1]), relu(frame[n - m_cp])),
                            mx(relu(frame[n - 1]), relu(d)));
                e.addr = c * (m_rp / 2) * (m_cp / 2) + (rw / 2) * (m_cp / 2) + cl / 2;
                e.due  = tick + 1;
                q.push_back(e);
            end
            n++;
            if (n == m_m * m_rp * m_cp) begin
                armed = 0; done_at = tick + 1; fall_at = tick + 1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int k);
        repeat (k) drive(0, 0, 0, 1);
    endtask

    task automatic chk_list(input string nm, input int a0, input int a1, input int a2, input int a3);
        int exp4[4];
        exp4 = '{a0, a1, a2, a3};
        chk({nm, "_count"}, got.size(), 4);
        if (got.size() == 4)
            for (int i = 0; i < 4; i++) chk({nm, "_word"}, got[i], exp4[i]);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit ev;
        if (run_chk) begin
            if (tick == rise_at) busy_model = 1'b1;
            if (tick == fall_at) busy_model = 1'b0;
            ev = (q.size() > 0) && (q[0].due == tick);
            chk("out_valid", o_valid, ev);
            if (ev && o_valid) begin
                chk("out_data", o_data, q[0].val);
                chk("out_addr", o_addr, q[0].addr);
            end
            if (ev) void'(q.pop_front());
            if (o_valid) begin
                got.push_back(o_data); n_valid++; last_addr = o_addr;
            end
            chk("done", o_done, tick == done_at);
            if (o_done) n_done++;
            chk("busy", o_busy, busy_model);
        end
    end

    task automatic ramp16;
        for (int i = 0; i < 16; i++) drive(0, 1, i, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_data", ifa.out_data, 0);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_out_addr", ifa.out_addr, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_done", ifa.done, 0);
        run_chk = 1'b1;
        idle(2);

        // 4x4 ramp
        sel = 0; m_m = 1; m_rp = 4; m_cp = 4;
        got.delete(); n_done = 0;
        drive(1, 0, 0, 1); ramp16(); idle(3);
        chk_list("ramp", 5, 7, 13, 15);
        chk("ramp_done_count", n_done, 1);

        // all negative
        got.delete();
        drive(1, 0, 0, 1);
        for (int i = 0; i < 16; i++) drive(0, 1, -5, 1);
        idle(3);
        chk_list("neg", 0, 0, 0, 0);

        // mixed first window {-1,3,-7,2}
        got.delete();
        drive(1, 0, 0, 1);
        for (int i = 0; i < 16; i++)
            drive(0, 1, (i == 0) ? -1 : (i == 1) ? 3 : (i == 4) ? -7 : (i == 5) ? 2 : -5, 1);
        idle(3);
        chk_list("mixed", 3, 0, 0, 0);

        // odd 5x5
        sel = 1; m_m = 1; m_rp = 5; m_cp = 5;
        got.delete(); n_done = 0;
        drive(1, 0, 0, 1);
        for (int i = 0; i < 25; i++) drive(0, 1, i, 1);
        idle(3);
        chk_list("odd", 6, 8, 16, 18);
        chk("odd_done_count", n_done, 1);

        // default geometry, random data with random gaps
        sel = 2; m_m = 3; m_rp = 25; m_cp = 25;
        n_valid = 0; n_done = 0; last_addr = -1;
        drive(1, 0, 0, 1);
        for (int i = 0; i < 1875; i++) begin
            if ($urandom_range(3) == 0) drive(0, 0, 0, 1);
            drive(0, 1, int'($urandom), 1);
        end
        idle(3);
        chk("full_valid_count", n_valid, 432);
        chk("full_last_addr", last_addr, 431);
        chk("full_done_count", n_done, 1);

        // reset mid-frame, then ignored input, then restart
        sel = 0; m_m = 1; m_rp = 4; m_cp = 4;
        drive(1, 0, 0, 1);
        for (int i = 0; i < 10; i++) drive(0, 1, i, 1);
        drive(0, 0, 0, 0);
        chk("mid_rst_out_data", ifa.out_data, 0);
        chk("mid_rst_out_valid", ifa.out_valid, 0);
        chk("mid_rst_out_addr", ifa.out_addr, 0);
        chk("mid_rst_busy", ifa.busy, 0);
        chk("mid_rst_done", ifa.done, 0);
        got.delete();
        for (int i = 0; i < 16; i++) drive(0, 1, i, 1);
        idle(2);
        chk("post_rst_ignored", got.size(), 0);
        drive(1, 0, 0, 1); ramp16(); idle(3);
        chk_list("restart", 5, 7, 13, 15);

        // start collides with a sample
        got.delete();
        drive(1, 1, 99, 1); ramp16(); idle(3);
        chk_list("collide", 5, 7, 13, 15);

        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/relu_maxpool.md
# relu_maxpool

Streaming ReLU plus 2×2, stride-2 max-pool stage directly downstream of the `CNN` convolution core. It consumes the core's output write stream (`O_din`/`O_wren`) in raster order: channel-major, then row, then column. It emits one pooled, rectified word per 2×2 window together with a sequential output address, so that the next layer or a capture memory can store the result.

## Interface
Parameters:
- `M`, 3: number of output feature maps (channels) from the convolution.
- `RP`, 25: rows per map (R·S−K+1).
- `CP`, 25: columns per map (C·S−K+1).
- `DW`, 32: data width; two's-complement signed.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-low (0 = reset).
- `start`  in  1  one-cycle pulse; arms the block for a new frame of M·RP·CP inputs.
- `in_data`  in  DW  convolution result; connects to `O_din`.
- `in_valid`  in  1  input qualifier; connects to `O_wren`.
- `out_data`  out  DW  pooled value, always ≥ 0.
- `out_valid`  out  1  one-cycle strobe per pooled word.
- `out_addr`  out  32  index of the current `out_data` word, 0 … M·(RP/2)·(CP/2)−1.
- `busy`  out  1  high from `start` until the frame's last input is consumed.
- `done`  out  1  one-cycle pulse after the last pooled word.

## Operation
- **States:** IDLE and RUN.
  - IDLE→RUN on `start`.
  - RUN→IDLE when the input at ch=M−1, row=RP−1, col=CP−1 is accepted.
  - `start` in RUN restarts the frame: counters clear and line buffer contents become don't-care.
  - `in_valid` in IDLE is ignored.
- **Counters:** `col` (0…CP−1), `row` (0…RP−1), `ch` (0…M−1), advanced on each accepted input. `col` wraps into `row`, and `row` wraps into `ch`.
- **ReLU:** v = (in_data < 0) ? 0 : in_data, using a signed compare. All max operations are signed; since v ≥ 0, results are non-negative.
- **Horizontal pair:**
  - Even `col`: latch v into `h_reg`.
  - Odd `col`: h = max(h_reg, v).
- **Vertical pair:**
  - Even `row`, odd `col`: write h into `lbuf[col>>1]`.
  - Odd `row`, odd `col`: pooled = max(lbuf[col>>1], h), issued as output.
- **Odd-dimension truncation:**
  - If CP is odd, the input at col=CP−1 is consumed (counters advance) but discarded.
  - If RP is odd, row RP−1 is consumed and discarded; no output is produced for it.
- **Address:** `out_addr` clears on `start` and increments after each `out_valid`.
- **Gaps:** `in_valid` may deassert for any number of cycles; state holds.

## Timing
- **Reset values:** `out_data`=0, `out_valid`=0, `out_addr`=0, `busy`=0, `done`=0, state=IDLE, all counters 0.
- **Latency:** `out_valid`/`out_data` are registered, high on the cycle after the accepted input that completes a window (odd row, odd col).
- **Throughput:** one input per cycle, sustained with no back-pressure. The block must accept `in_valid` on every cycle.
- **`busy`:** rises the cycle after `start`; falls the cycle after the last input is accepted.
- **`done`:** pulses one cycle after the last input is accepted.
  - If that input completes a window, `done` coincides with the final `out_valid`.
  - If that input is discarded (odd RP or odd CP), `done` still fires on the same relative cycle.
- **`start` with `in_valid` in the same cycle:** `start` wins and the sample is dropped.
- **Reset mid-frame:** returns to IDLE immediately. No further `out_valid` or `done` until a new `start`.
- **Word address tracking:** `out_addr` is valid in the same cycle as `out_valid` and holds the address of that word.

## Structure
- **Shared package `cnn_pkg`:**
  - `DW`.
  - State encoding (IDLE, RUN).
  - Derived constants: PR=RP/2, PC=CP/2, OUT_WORDS=M·PR·PC.
  - Signed `max` function.
- **Sub-module `pool_line_buf`:** PC×DW register array with one write port and one asynchronous read port, both indexed by `col>>1`. No reset on its contents.
- **Top level:** FSM, counters, ReLU, pair logic, output registers.

## Test plan
- **4×4 ramp** (M=1, RP=CP=4): inputs 0…15 back-to-back → out 5,7,13,15 at out_addr 0…3; `done` with the 4th output.
- **Negative input** (M=1, RP=CP=4): all inputs −5 (0xFFFFFFFB) → four outputs of 0. Mixed window {−1, 3, −7, 2} → 3.
- **Odd dimensions** (M=1, RP=CP=5): inputs 0…24 → out 6,8,16,18. No output for row 4 or col 4. `done` one cycle after input 24.
- **Default parameters:** 1875 inputs with random one-cycle `in_valid` gaps → exactly 432 `out_valid` strobes matching a golden model; out_addr ends at 431; exactly one `done`.
- **Reset/restart:**
  - Assert `rst`=0 after 10 inputs → outputs return to reset values; `in_valid` afterwards is ignored.
  - New `start` then the 4×4 ramp → 5,7,13,15 from addr 0.
- **Start collision:** `start` together with `in_valid`(99), then the 4×4 ramp → 99 is dropped; outputs are 5,7,13,15.
